// File: rtl/pool2.sv
// pool2: 2x2 stride-2 signed max pooling over N_MAPS feature maps, one window per cycle.
// Optional POOL2_STREAM_EN adds a per-write result stream (out_valid/out_data/out_f/out_oi/out_oj).
module pool2 #(
    parameter int N_MAPS = 32,
    parameter int IN_DIM = 14,
    localparam int OUT_DIM = IN_DIM / 2,
    localparam int FW = (N_MAPS > 1) ? $clog2(N_MAPS) : 1,
    localparam int DW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [31:0]  conv2_maps [N_MAPS][IN_DIM][IN_DIM],
    output logic                done,
    output logic                busy,
`ifdef POOL2_STREAM_EN
    output logic                out_valid,
    output logic signed [31:0]  out_data,
    output logic [FW-1:0]       out_f,
    output logic [DW-1:0]       out_oi,
    output logic [DW-1:0]       out_oj,
`endif
    output logic signed [31:0]  pool2_maps [N_MAPS][OUT_DIM][OUT_DIM]
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state;
    logic [FW-1:0] f;
    logic [DW-1:0] oi, oj;
    logic        dcnt;

    logic              s1_valid;
    logic [FW-1:0]     s1_f;
    logic [DW-1:0]     s1_oi, s1_oj;
    logic signed [31:0] s1_m0, s1_m1;

    logic [DW:0] r0, r1, c0, c1;
    logic        last_win;

    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

    assign r0 = {oi, 1'b0};
    assign r1 = {oi, 1'b1};
    assign c0 = {oj, 1'b0};
    assign c1 = {oj, 1'b1};

    assign last_win = (f == FW'(N_MAPS - 1)) &&
                      (oi == DW'(OUT_DIM - 1)) &&
                      (oj == DW'(OUT_DIM - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            f     <= '0;
            oi    <= '0;
            oj    <= '0;
            dcnt  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        f     <= '0;
                        oi    <= '0;
                        oj    <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_win) begin
                        dcnt  <= 1'b0;
                        state <= DRAIN;
                    end else if (oj != DW'(OUT_DIM - 1)) begin
                        oj <= oj + 1'b1;
                    end else begin
                        oj <= '0;
                        if (oi != DW'(OUT_DIM - 1)) begin
                            oi <= oi + 1'b1;
                        end else begin
                            oi <= '0;
                            f  <= f + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt) state <= DONE;
                    else      dcnt  <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: horizontal max of the top and bottom window rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_oi    <= '0;
            s1_oj    <= '0;
            s1_m0    <= '0;
            s1_m1    <= '0;
        end else begin
            s1_valid <= (state == ISSUE);
            s1_f     <= f;
            s1_oi    <= oi;
            s1_oj    <= oj;
            s1_m0    <= smax(conv2_maps[f][r0][c0], conv2_maps[f][r0][c1]);
            s1_m1    <= smax(conv2_maps[f][r1][c0], conv2_maps[f][r1][c1]);
        end
    end

    // Stage 2: vertical max, written in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_MAPS; i++)
                for (int j = 0; j < OUT_DIM; j++)
                    for (int k = 0; k < OUT_DIM; k++)
                        pool2_maps[i][j][k] <= '0;
        end else if (s1_valid) begin
            pool2_maps[s1_f][s1_oi][s1_oj] <= smax(s1_m0, s1_m1);
        end
    end

`ifdef POOL2_STREAM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_f     <= '0;
            out_oi    <= '0;
            out_oj    <= '0;
        end else begin
            out_valid <= s1_valid;
            out_data  <= smax(s1_m0, s1_m1);
            out_f     <= s1_f;
            out_oi    <= s1_oi;
            out_oj    <= s1_oj;
        end
    end
`endif

endmodule

// File: tb/tb_pool2.sv
// tb_pool2: directed + randomized runs of pool2 against a window-max reference model.
// Covers ramp, signed extremes, slot positions, ignored restart, mid-run reset.
module tb_pool2;

    localparam int NM = 32;
    localparam int ID = 14;
    localparam int OD = 7;
    localparam int RUN_CYC = NM * OD * OD + 4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;
    logic busy;
    logic signed [31:0] x [NM][ID][ID];
    logic signed [31:0] y [NM][OD][OD];
`ifdef POOL2_STREAM_EN
    logic               out_valid;
    logic signed [31:0] out_data;
    logic [4:0]         out_f;
    logic [2:0]         out_oi;
    logic [2:0]         out_oj;
    int sv_cnt;
    int sv_last;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pool2 #(.N_MAPS(NM), .IN_DIM(ID)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .conv2_maps (x),
        .done       (done),
        .busy       (busy),
`ifdef POOL2_STREAM_EN
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_f      (out_f),
        .out_oi     (out_oi),
        .out_oj     (out_oj),
`endif
        .pool2_maps (y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic fill_rand();
        for (int f = 0; f < NM; f++)
            for (int r = 0; r < ID; r++)
                for (int c = 0; c < ID; c++)
                    x[f][r][c] = $urandom;
    endtask

    task automatic fill_const(input logic signed [31:0] v);
        for (int f = 0; f < NM; f++)
            for (int r = 0; r < ID; r++)
                for (int c = 0; c < ID; c++)
                    x[f][r][c] = v;
    endtask

    // Reference: largest of the four window values, signed.
    task automatic check_all(input string tag);
        logic signed [31:0] e;
        for (int f = 0; f < NM; f++)
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++) begin
                    e = x[f][2*i][2*j];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (x[f][2*i+dr][2*j+dc] > e)
                                e = x[f][2*i+dr][2*j+dc];
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, f, i, j), y[f][i][j], e);
                end
    endtask

    // Caller sets start up at a negedge; start is sampled at the next posedge.
    task automatic run(input int pulse_at, input int rst_at);
        int n;
        start = 1'b1;
`ifdef POOL2_STREAM_EN
        sv_cnt  = 0;
        sv_last = -1;
`endif
        @(posedge clk);
        n = 1;
        #1 start = 1'b0;
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_set", 32'(busy), 32'd1);
        while (!done && n < 3000) begin
            if (n == pulse_at) start = 1'b1;
            @(posedge clk);
            n++;
            #1 start = 1'b0;
`ifdef POOL2_STREAM_EN
            if (out_valid) begin
                sv_cnt++;
                if (sv_cnt == 1) begin
                    chk("stream_first_lat", 32'(n), 32'd3);
                    chk("stream_first_idx", {21'd0, out_f, out_oi, out_oj}, 32'd0);
                end
                sv_last = int'({out_f, out_oi, out_oj});
            end
`endif
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_map_clr", y[0][0][0], 32'd0);
                chk("abort_map_clr2", y[NM-1][OD-1][OD-1], 32'd0);
                repeat (2) begin
                    @(posedge clk);
                    #1 chk("abort_done_hold", 32'(done), 32'd0);
                end
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        chk("latency", 32'(n), 32'(RUN_CYC));
        chk("busy_clear", 32'(busy), 32'd0);
`ifdef POOL2_STREAM_EN
        chk("stream_count", 32'(sv_cnt), 32'(NM * OD * OD));
        chk("stream_last_idx", 32'(sv_last), {21'd0, 5'd31, 3'd6, 3'd6});
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_const(32'sd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_map", y[5][3][4], 32'd0);
`ifdef POOL2_STREAM_EN
        chk("rst_out_valid", 32'(out_valid), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Ramp: window max is always the bottom-right element.
        for (int f = 0; f < NM; f++)
            for (int r = 0; r < ID; r++)
                for (int c = 0; c < ID; c++)
                    x[f][r][c] = f * 1000 + r * 14 + c;
        run(0, 0);
        check_all("ramp");
        chk("ramp_3_2_5", y[3][2][5], 32'(3000 + 5 * 14 + 11));
        chk("done_level", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_stays", 32'(done), 32'd1);

        // Signed windows on a random background.
        fill_rand();
        x[0][0][0] = -5;          x[0][0][1] = -3;
        x[0][1][0] = -7;          x[0][1][1] = -9;
        x[0][0][2] = 32'h7fffffff; x[0][0][3] = -1;
        x[0][1][2] = 0;           x[0][1][3] = 1;
        run(0, 0);
        check_all("signed");
        chk("signed_neg", y[0][0][0], -32'sd3);
        chk("signed_maxpos", y[0][0][1], 32'h7fffffff);

        // 100 in one window slot at a time, zeros elsewhere.
        for (int q = 0; q < 4; q++) begin
            fill_const(32'sd0);
            for (int f = 0; f < NM; f++)
                for (int i = 0; i < OD; i++)
                    for (int j = 0; j < OD; j++)
                        x[f][2*i + q/2][2*j + q%2] = 100;
            @(negedge clk);
            run(0, 0);
            check_all($sformatf("slot%0d", q));
            chk($sformatf("slot%0d_corner", q), y[NM-1][OD-1][OD-1], 32'd100);
        end

        // A second start mid-run is ignored.
        fill_rand();
        @(negedge clk);
        run(500, 0);
        check_all("restart_ignored");

        // Reset at cycle 800 aborts; a new run starts on the first edge after release.
        fill_rand();
        @(negedge clk);
        run(0, 800);
        fill_const(32'sd1);
        run(0, 0);
        check_all("after_reset");
        chk("after_reset_val", y[17][4][2], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
